marian_fpga_rst_ctrl: RTL and testbench

Reset sequencer for the Marian FPGA prototype top. It combines the board reset button and the clock-generator lock into staged, glitch-free reset releases: peripherals first, then the core. It also debounces the JTAG reset button and records the cause of the last system reset. It sits between the clock generator and marian_top, replacing the direct `locked & ~rst` gating.

---
 rtl/marian_fpga_rst_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_marian_fpga_rst_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/marian_fpga_rst_ctrl.sv
// Reset sequencer for the Marian FPGA prototype top.
// Combines the board reset button and the clock-generator lock into a staged
// reset release: peripherals first, then the core after a short delay. It
// also debounces the JTAG reset button and records why the system last reset.
//
// Ports:
//   clk_i          clock (clock-generator output)
//   rst_i          asynchronous active-high reset (board button)
//   pll_locked_i   clock-generator lock, asynchronous to clk_i
//   jtag_btn_i     JTAG reset button, active-high, asynchronous, bouncy
//   sw_rst_req_i   synchronous single-cycle software reset request
//   periph_rstn_o  active-low peripheral reset
//   core_rstn_o    active-low core/vector-unit reset
//   jtag_trstn_o   active-low JTAG TAP reset
//   sys_ready_o    high only while the sequencer is in RUN
//   rst_cause_o    00 power-on/button, 01 lock loss, 10 software
module marian_fpga_rst_ctrl #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned HOLD_CYCLES        = 64,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY        = 16,
    parameter int unsigned DEBOUNCE_CYCLES    = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       jtag_btn_i,
    input  logic       sw_rst_req_i,
    output logic       periph_rstn_o,
    output logic       core_rstn_o,
    output logic       jtag_trstn_o,
    output logic       sys_ready_o,
    output logic [1:0] rst_cause_o
);

    localparam int unsigned CNT_MAX_A = (HOLD_CYCLES > LOCK_STABLE_CYCLES) ? HOLD_CYCLES
                                                                           : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > STAGE_DELAY) ? CNT_MAX_A : STAGE_DELAY;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    typedef enum logic [1:0] {
        S_HOLD       = 2'd0,
        S_WAIT_LOCK  = 2'd1,
        S_REL_PERIPH = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    // Input synchronisers
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   locked_s;
    logic                   btn_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_sync <= '0;
            btn_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], jtag_btn_i};
        end
    end

    assign locked_s = lock_sync[SYNC_STAGES-1];
    assign btn_s    = btn_sync[SYNC_STAGES-1];

    // JTAG button debounce; powers up as "pressed" so the TAP starts in reset
    logic            jtag_db;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            jtag_db <= 1'b1;
            db_cnt  <= '0;
        end else if (btn_s != jtag_db) begin
            if (db_cnt == DB_LAST) begin
                jtag_db <= btn_s;
                db_cnt  <= '0;
            end else begin
                db_cnt  <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Sequencer state register
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_d;
    logic             first_rel_q, first_rel_d;
    logic             periph_d, core_d, ready_d, trstn_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_HOLD;
            cnt_q         <= '0;
            first_rel_q   <= 1'b0;
            rst_cause_o   <= CAUSE_POR;
            periph_rstn_o <= 1'b0;
            core_rstn_o   <= 1'b0;
            sys_ready_o   <= 1'b0;
            jtag_trstn_o  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            first_rel_q   <= first_rel_d;
            rst_cause_o   <= cause_d;
            periph_rstn_o <= periph_d;
            core_rstn_o   <= core_d;
            sys_ready_o   <= ready_d;
            jtag_trstn_o  <= trstn_d;
        end
    end

    // Next-state and registered-output logic; cnt is cleared on every state change
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        cause_d     = rst_cause_o;
        first_rel_d = first_rel_q;

        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d     = S_WAIT_LOCK;
                    cnt_d       = '0;
                    first_rel_d = 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // Any unlocked cycle restarts the stability count
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_REL_PERIPH;
                    cnt_d   = '0;
                end
            end
            S_REL_PERIPH: begin
                if (!locked_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_LOCK;
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                // Lock loss takes priority over a coincident software request
                if (!locked_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_LOCK;
                end else if (sw_rst_req_i) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_SW;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase

        periph_d = (state_d == S_REL_PERIPH) || (state_d == S_RUN);
        core_d   = (state_d == S_RUN);
        ready_d  = (state_d == S_RUN);
        // TAP reset follows only the button once the first release has happened
        trstn_d  = first_rel_q & ~jtag_db;
    end

endmodule

// File: tb/tb_marian_fpga_rst_ctrl.sv
// Directed testbench for marian_fpga_rst_ctrl with small timing parameters.
module tb_marian_fpga_rst_ctrl;

    localparam int unsigned SYNC_STAGES        = 2;
    localparam int unsigned HOLD_CYCLES        = 4;
    localparam int unsigned LOCK_STABLE_CYCLES = 8;
    localparam int unsigned STAGE_DELAY        = 2;
    localparam int unsigned DEBOUNCE_CYCLES    = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       pll_locked_i = 1'b1;
    logic       jtag_btn_i = 1'b0;
    logic       sw_rst_req_i = 1'b0;
    logic       periph_rstn_o;
    logic       core_rstn_o;
    logic       jtag_trstn_o;
    logic       sys_ready_o;
    logic [1:0] rst_cause_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // {periph, core, ready, trstn, cause[1:0]}
    logic [5:0] obs;
    logic [5:0] exp_v;
    assign obs = {periph_rstn_o, core_rstn_o, sys_ready_o, jtag_trstn_o, rst_cause_o};

    always #5 clk_i = ~clk_i;

    marian_fpga_rst_ctrl #(
        .SYNC_STAGES       (SYNC_STAGES),
        .HOLD_CYCLES       (HOLD_CYCLES),
        .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
        .STAGE_DELAY       (STAGE_DELAY),
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pll_locked_i (pll_locked_i),
        .jtag_btn_i   (jtag_btn_i),
        .sw_rst_req_i (sw_rst_req_i),
        .periph_rstn_o(periph_rstn_o),
        .core_rstn_o  (core_rstn_o),
        .jtag_trstn_o (jtag_trstn_o),
        .sys_ready_o  (sys_ready_o),
        .rst_cause_o  (rst_cause_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Hold rst_i for a few edges, check the reset state, release just after an edge
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        exp_v = 6'b000000;
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL reset_state: got %b expected %b", obs, exp_v);
            tests_failed++;
        end
        rst_i = 1'b0;
    endtask

    task automatic test_power_on();
        pll_locked_i = 1'b1;
        jtag_btn_i   = 1'b0;
        sw_rst_req_i = 1'b0;
        test_reset();
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp_v = {(e >= 12), (e >= 14), (e >= 14), (e >= 5), 2'b00};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL power_on edge %0d: got %b expected %b", e, obs, exp_v);
                tests_failed++;
            end
        end
    endtask

    // One-cycle lock drop during WAIT_LOCK restarts the stable count
    task automatic test_lock_glitch();
        test_reset();
        for (int e = 1; e <= 22; e++) begin
            tick();
            exp_v = {(e >= 18), (e >= 20), (e >= 20), (e >= 5), 2'b00};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL lock_glitch edge %0d: got %b expected %b", e, obs, exp_v);
                tests_failed++;
            end
            if (e == 7) pll_locked_i = 1'b0;
            if (e == 8) pll_locked_i = 1'b1;
        end
    endtask

    task automatic test_lock_loss_run();
        pll_locked_i = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            exp_v = (n < 3) ? 6'b111100 : 6'b000101;
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL lock_loss edge %0d: got %b expected %b", n, obs, exp_v);
                tests_failed++;
            end
        end
        pll_locked_i = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            exp_v = {(n >= 12), (n >= 14), (n >= 14), 1'b1, 2'b01};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL lock_loss_rerelease edge %0d: got %b expected %b", n, obs, exp_v);
                tests_failed++;
            end
        end
    endtask

    // Request honoured in RUN, ignored in WAIT_LOCK
    task automatic test_sw_reset();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        exp_v = 6'b000110;
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL sw_reset_entry: got %b expected %b", obs, exp_v);
            tests_failed++;
        end
        for (int n = 1; n <= 14; n++) begin
            tick();
            exp_v = {(n >= 12), (n >= 14), (n >= 14), 1'b1, 2'b10};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL sw_reset_wait_lock edge %0d: got %b expected %b", n, obs, exp_v);
                tests_failed++;
            end
            if (n == 5) sw_rst_req_i = 1'b1;
            if (n == 6) sw_rst_req_i = 1'b0;
        end
    endtask

    // Software request on the same edge the lock loss is seen: lock cause wins
    task automatic test_simultaneous();
        pll_locked_i = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            if (n == 3) sw_rst_req_i = 1'b1;
            tick();
            sw_rst_req_i = 1'b0;
            exp_v = (n < 3) ? 6'b111110 : 6'b000101;
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL simultaneous edge %0d: got %b expected %b", n, obs, exp_v);
                tests_failed++;
            end
        end
        pll_locked_i = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            exp_v = {(n >= 12), (n >= 14), (n >= 14), 1'b1, 2'b01};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL simultaneous_rerelease edge %0d: got %b expected %b", n, obs, exp_v);
                tests_failed++;
            end
        end
    endtask

    task automatic test_jtag_debounce();
        // 3-cycle press is rejected
        jtag_btn_i = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (n == 3) jtag_btn_i = 1'b0;
            exp_v = 6'b111101;
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL debounce_short edge %0d: got %b expected %b", n, obs, exp_v);
                tests_failed++;
            end
        end
        // 5-cycle press is accepted, then the release is accepted too
        jtag_btn_i = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 5) jtag_btn_i = 1'b0;
            exp_v = {3'b111, !(n >= 7 && n <= 11), 2'b01};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL debounce_long edge %0d: got %b expected %b", n, obs, exp_v);
                tests_failed++;
            end
        end
    endtask

    // rst_i mid-RUN clears outputs without waiting for a clock edge
    task automatic test_async_reset();
        rst_i = 1'b1;
        #1;
        exp_v = 6'b000000;
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL async_reset: got %b expected %b", obs, exp_v);
            tests_failed++;
        end
        repeat (2) tick();
        rst_i = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp_v = 6'b000000;
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL async_reset_hold edge %0d: got %b expected %b", e, obs, exp_v);
                tests_failed++;
            end
        end
    endtask

    initial begin
        test_power_on();
        test_lock_glitch();
        test_lock_loss_run();
        test_sw_reset();
        test_simultaneous();
        test_jtag_debounce();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
